// File: rtl/mux7to1_reg_if.sv
// Bus bundle for the registered 7-to-1 selector.
// Master drives select/data/valid; slave returns the registered result.
interface mux7to1_reg_if #(
    parameter int WIDTH = 1
);
    logic [2:0]       Sel;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] C;
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] E;
    logic [WIDTH-1:0] F;
    logic [WIDTH-1:0] G;
    logic             in_valid;
    logic [WIDTH-1:0] Z;
    logic             out_valid;
    logic             sel_err;

    modport master (
        output Sel, A, B, C, D, E, F, G, in_valid,
        input  Z, out_valid, sel_err
    );

    modport slave (
        input  Sel, A, B, C, D, E, F, G, in_valid,
        output Z, out_valid, sel_err
    );
endinterface

// File: rtl/mux7to1_reg.sv
// Registered 7-to-1 selector with valid tag and illegal-select flag.
// One cycle latency; no combinational path from inputs to outputs.
module mux7to1_reg #(
    parameter int WIDTH = 1
) (
    input  logic          clk,
    input  logic          rst,
    mux7to1_reg_if.slave  bus
);
    logic [WIDTH-1:0] w_data;
    logic             w_err;

    logic [WIDTH-1:0] r_z;
    logic             r_valid;
    logic             r_err;

    // Sel==7 or unknown falls to default: zero data, flag error.
    always_comb begin
        w_data = '0;
        w_err  = 1'b0;
        case (bus.Sel)
            3'd0:    w_data = bus.A;
            3'd1:    w_data = bus.B;
            3'd2:    w_data = bus.C;
            3'd3:    w_data = bus.D;
            3'd4:    w_data = bus.E;
            3'd5:    w_data = bus.F;
            3'd6:    w_data = bus.G;
            default: begin
                w_data = '0;
                w_err  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_z     <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_z   <= w_data;
                r_err <= w_err;
            end
        end
    end

    assign bus.Z         = r_z;
    assign bus.out_valid = r_valid;
    assign bus.sel_err   = r_err;
endmodule

// File: tb/tb_mux7to1_reg.sv
// Directed testbench for mux7to1_reg (WIDTH=1 and WIDTH=8 instances).
// Inputs change 1ns after posedge; outputs checked 1ns after posedge.
module tb_mux7to1_reg;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    mux7to1_reg_if #(.WIDTH(1)) bus1 ();
    mux7to1_reg_if #(.WIDTH(8)) bus8 ();

    mux7to1_reg #(.WIDTH(1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    mux7to1_reg #(.WIDTH(8)) u_dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string name, input logic [7:0] z,
                        input logic ov, input logic er,
                        input logic [7:0] ez, input logic eov, input logic eer);
        checks++;
        if (z !== ez || ov !== eov || er !== eer) begin
            errors++;
            $display("FAIL %s: Z=%h out_valid=%b sel_err=%b, required Z=%h out_valid=%b sel_err=%b",
                     name, z, ov, er, ez, eov, eer);
        end
    endtask

    task automatic set1(input logic [6:0] v);
        bus1.A = v[0]; bus1.B = v[1]; bus1.C = v[2]; bus1.D = v[3];
        bus1.E = v[4]; bus1.F = v[5]; bus1.G = v[6];
    endtask

    task automatic test_reset();
        bus1.Sel = 3'd0; set1(7'h00); bus1.in_valid = 1'b0;
        bus8.Sel = 3'd0; bus8.in_valid = 1'b0;
        bus8.A = 8'h00; bus8.B = 8'h00; bus8.C = 8'h00; bus8.D = 8'h00;
        bus8.E = 8'h00; bus8.F = 8'h00; bus8.G = 8'h00;
        rst = 1'b1;
        #3;
        chk1("reset_held", {7'd0, bus1.Z}, bus1.out_valid, bus1.sel_err, 8'h00, 1'b0, 1'b0);
        step();
        step();
        rst = 1'b0;
        step();
        step();
        chk1("reset_idle", {7'd0, bus1.Z}, bus1.out_valid, bus1.sel_err, 8'h00, 1'b0, 1'b0);
        chk1("reset_idle8", bus8.Z, bus8.out_valid, bus8.sel_err, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_basic();
        bus1.Sel = 3'd0;
        set1(7'b1001110);
        bus1.in_valid = 1'b1;
        step();
        chk1("basic_a0", {7'd0, bus1.Z}, bus1.out_valid, bus1.sel_err, 8'h00, 1'b1, 1'b0);
        set1(7'b1001111);
        step();
        chk1("basic_a1", {7'd0, bus1.Z}, bus1.out_valid, bus1.sel_err, 8'h01, 1'b1, 1'b0);
    endtask

    task automatic test_sweep();
        bus1.in_valid = 1'b1;
        for (int s = 0; s < 7; s++) begin
            bus1.Sel = 3'(s);
            set1(7'(1 << s));
            step();
            chk1($sformatf("onehot_sel%0d", s), {7'd0, bus1.Z},
                 bus1.out_valid, bus1.sel_err, 8'h01, 1'b1, 1'b0);
            set1(~7'(1 << s));
            step();
            chk1($sformatf("inverse_sel%0d", s), {7'd0, bus1.Z},
                 bus1.out_valid, bus1.sel_err, 8'h00, 1'b1, 1'b0);
        end
    endtask

    task automatic test_illegal();
        bus1.in_valid = 1'b1;
        bus1.Sel = 3'd7;
        set1(7'h7F);
        step();
        chk1("illegal_sel7", {7'd0, bus1.Z}, bus1.out_valid, bus1.sel_err, 8'h00, 1'b1, 1'b1);
        bus1.Sel = 3'd6;
        set1(7'b1000000);
        step();
        chk1("recover_sel6", {7'd0, bus1.Z}, bus1.out_valid, bus1.sel_err, 8'h01, 1'b1, 1'b0);
    endtask

    task automatic test_hold();
        bus1.in_valid = 1'b1;
        bus1.Sel = 3'd2;
        set1(7'b0000100);
        step();
        chk1("hold_capture", {7'd0, bus1.Z}, bus1.out_valid, bus1.sel_err, 8'h01, 1'b1, 1'b0);
        bus1.in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus1.C = ~bus1.C;
            step();
            chk1($sformatf("hold_idle%0d", k), {7'd0, bus1.Z},
                 bus1.out_valid, bus1.sel_err, 8'h01, 1'b0, 1'b0);
        end
        bus1.Sel = 3'd7;
        step();
        chk1("hold_idle_sel7", {7'd0, bus1.Z}, bus1.out_valid, bus1.sel_err, 8'h01, 1'b0, 1'b0);
    endtask

    task automatic test_async_reset();
        bus1.in_valid = 1'b1;
        bus1.Sel = 3'd1;
        set1(7'b0000010);
        step();
        chk1("pre_rst", {7'd0, bus1.Z}, bus1.out_valid, bus1.sel_err, 8'h01, 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk1("async_rst", {7'd0, bus1.Z}, bus1.out_valid, bus1.sel_err, 8'h00, 1'b0, 1'b0);
        step();
        chk1("rst_discard", {7'd0, bus1.Z}, bus1.out_valid, bus1.sel_err, 8'h00, 1'b0, 1'b0);
        rst = 1'b0;
        step();
        chk1("post_rst_cap", {7'd0, bus1.Z}, bus1.out_valid, bus1.sel_err, 8'h01, 1'b1, 1'b0);
        bus1.in_valid = 1'b0;
    endtask

    task automatic test_width8();
        bus8.A = 8'h3C; bus8.B = 8'h11; bus8.C = 8'h22; bus8.D = 8'h44;
        bus8.E = 8'h88; bus8.F = 8'hA5; bus8.G = 8'hF0;
        bus8.in_valid = 1'b1;
        bus8.Sel = 3'd5;
        step();
        chk1("w8_sel5", bus8.Z, bus8.out_valid, bus8.sel_err, 8'hA5, 1'b1, 1'b0);
        bus8.Sel = 3'd7;
        step();
        chk1("w8_sel7", bus8.Z, bus8.out_valid, bus8.sel_err, 8'h00, 1'b1, 1'b1);
        bus8.in_valid = 1'b0;
        bus8.Sel = 3'd0;
        step();
        chk1("w8_idle", bus8.Z, bus8.out_valid, bus8.sel_err, 8'h00, 1'b0, 1'b1);
    endtask

    task automatic test_back_to_back();
        logic [2:0] sel_v [8];
        logic [7:0] exp_z [8];
        logic       exp_e [8];
        sel_v = '{3'd0, 3'd6, 3'd3, 3'd7, 3'd1, 3'd4, 3'd2, 3'd5};
        exp_z = '{8'h3C, 8'hF0, 8'h44, 8'h00, 8'h11, 8'h88, 8'h22, 8'hA5};
        exp_e = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        bus8.in_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            bus8.Sel = sel_v[k];
            step();
            chk1($sformatf("b2b_%0d", k), bus8.Z, bus8.out_valid, bus8.sel_err,
                 exp_z[k], 1'b1, exp_e[k]);
        end
        bus8.in_valid = 1'b0;
        step();
        chk1("b2b_tail", bus8.Z, bus8.out_valid, bus8.sel_err, 8'hA5, 1'b0, 1'b0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_sweep();
        test_illegal();
        test_hold();
        test_async_reset();
        test_width8();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
